// File: rtl/ascii_to_scancode.sv
// ASCII character to PS/2 Set-2 make/break byte sequence, with an optional Left Shift wrapper.
// Optional build macro CAPS_AWARE_EN adds a caps_lock input that flips the shift wrapper for letters.
//
// state   | meaning
// --------+--------------------------------------------
// IDLE    | waiting for a character (ascii_ready=1)
// SH_MK   | presenting SHIFT_CODE (shift make)
// KEY_MK  | presenting key code (make)
// KEY_F0  | presenting F0 (key break prefix)
// KEY_BRK | presenting key code (break)
// SH_F0   | presenting F0 (shift break prefix)
// SH_BRK  | presenting SHIFT_CODE (shift break)
module ascii_to_scancode #(
  parameter int unsigned GAP_CYCLES = 4,
  parameter logic [7:0]  SHIFT_CODE = 8'h12
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] ascii,
  input  logic       ascii_valid,
  output logic       ascii_ready,
  output logic [7:0] sc_byte,
  output logic       sc_valid,
  input  logic       sc_ready,
  output logic       busy,
  output logic       unsupported
`ifdef CAPS_AWARE_EN
  ,
  input  logic       caps_lock
`endif
);

  localparam int GW = (GAP_CYCLES < 1) ? 1 : $clog2(GAP_CYCLES + 1);

  typedef enum logic [2:0] {
    IDLE, SH_MK, KEY_MK, KEY_F0, KEY_BRK, SH_F0, SH_BRK
  } state_t;

  state_t          state, state_n;
  logic [7:0]      sc_byte_n, code_q, code_n;
  logic            sc_valid_n, shift_q, shift_n, unsup_n;
  logic [GW-1:0]   gap_cnt, gap_n;
  logic            caps_s;
  logic [9:0]      lk;

`ifdef CAPS_AWARE_EN
  assign caps_s = caps_lock;
`else
  assign caps_s = 1'b0;
`endif

  function automatic logic [7:0] letter_code(input logic [4:0] idx);
    logic [7:0] r;
    r = 8'h00;
    case (idx)
      5'd1:  r = 8'h1C;  5'd2:  r = 8'h32;  5'd3:  r = 8'h21;  5'd4:  r = 8'h23;
      5'd5:  r = 8'h24;  5'd6:  r = 8'h2B;  5'd7:  r = 8'h34;  5'd8:  r = 8'h33;
      5'd9:  r = 8'h43;  5'd10: r = 8'h3B;  5'd11: r = 8'h42;  5'd12: r = 8'h4B;
      5'd13: r = 8'h3A;  5'd14: r = 8'h31;  5'd15: r = 8'h44;  5'd16: r = 8'h4D;
      5'd17: r = 8'h15;  5'd18: r = 8'h2D;  5'd19: r = 8'h1B;  5'd20: r = 8'h2C;
      5'd21: r = 8'h3C;  5'd22: r = 8'h2A;  5'd23: r = 8'h1D;  5'd24: r = 8'h22;
      5'd25: r = 8'h35;  5'd26: r = 8'h1A;
      default: r = 8'h00;
    endcase
    return r;
  endfunction

  // Returns {supported, need_shift, code}.
  function automatic logic [9:0] lookup(input logic [7:0] c, input logic caps);
    logic       sup;
    logic       sh;
    logic [7:0] code;
    sup  = 1'b1;
    sh   = 1'b0;
    code = 8'h00;
    if (c >= 8'h61 && c <= 8'h7A) begin
      code = letter_code(c[4:0]);
      sh   = caps;
    end else if (c >= 8'h41 && c <= 8'h5A) begin
      code = letter_code(c[4:0]);
      sh   = ~caps;
    end else begin
      case (c)
        8'h30: code = 8'h45;  8'h31: code = 8'h16;  8'h32: code = 8'h1E;
        8'h33: code = 8'h26;  8'h34: code = 8'h25;  8'h35: code = 8'h2E;
        8'h36: code = 8'h36;  8'h37: code = 8'h3D;  8'h38: code = 8'h3E;
        8'h39: code = 8'h46;
        8'h21: begin code = 8'h16; sh = 1'b1; end
        8'h40: begin code = 8'h1E; sh = 1'b1; end
        8'h23: begin code = 8'h26; sh = 1'b1; end
        8'h24: begin code = 8'h25; sh = 1'b1; end
        8'h25: begin code = 8'h2E; sh = 1'b1; end
        8'h5E: begin code = 8'h36; sh = 1'b1; end
        8'h26: begin code = 8'h3D; sh = 1'b1; end
        8'h2A: begin code = 8'h3E; sh = 1'b1; end
        8'h28: begin code = 8'h46; sh = 1'b1; end
        8'h29: begin code = 8'h45; sh = 1'b1; end
        8'h20: code = 8'h29;
        8'h0D: code = 8'h5A;
        8'h08: code = 8'h66;
        8'h09: code = 8'h0D;
        8'h2D: code = 8'h4E;  8'h5F: begin code = 8'h4E; sh = 1'b1; end
        8'h3D: code = 8'h55;  8'h2B: begin code = 8'h55; sh = 1'b1; end
        8'h5B: code = 8'h54;  8'h7B: begin code = 8'h54; sh = 1'b1; end
        8'h5D: code = 8'h5B;  8'h7D: begin code = 8'h5B; sh = 1'b1; end
        8'h3B: code = 8'h4C;  8'h3A: begin code = 8'h4C; sh = 1'b1; end
        8'h27: code = 8'h52;  8'h22: begin code = 8'h52; sh = 1'b1; end
        8'h2C: code = 8'h41;  8'h3C: begin code = 8'h41; sh = 1'b1; end
        8'h2E: code = 8'h49;  8'h3E: begin code = 8'h49; sh = 1'b1; end
        8'h2F: code = 8'h4A;  8'h3F: begin code = 8'h4A; sh = 1'b1; end
        8'h60: code = 8'h0E;  8'h7E: begin code = 8'h0E; sh = 1'b1; end
        8'h5C: code = 8'h5D;  8'h7C: begin code = 8'h5D; sh = 1'b1; end
        default: sup = 1'b0;
      endcase
    end
    return {sup, sh, code};
  endfunction

  function automatic logic [7:0] byte_for(input state_t s, input logic [7:0] code);
    logic [7:0] r;
    case (s)
      SH_MK, SH_BRK: r = SHIFT_CODE;
      KEY_F0, SH_F0: r = 8'hF0;
      default:       r = code;
    endcase
    return r;
  endfunction

  function automatic state_t step(input state_t s, input logic sh);
    state_t r;
    case (s)
      SH_MK:   r = KEY_MK;
      KEY_MK:  r = KEY_F0;
      KEY_F0:  r = KEY_BRK;
      KEY_BRK: r = sh ? SH_F0 : IDLE;
      SH_F0:   r = SH_BRK;
      default: r = IDLE;
    endcase
    return r;
  endfunction

  assign lk = lookup(ascii, caps_s);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      sc_byte     <= 8'h00;
      sc_valid    <= 1'b0;
      gap_cnt     <= '0;
      code_q      <= 8'h00;
      shift_q     <= 1'b0;
      unsupported <= 1'b0;
    end else begin
      state       <= state_n;
      sc_byte     <= sc_byte_n;
      sc_valid    <= sc_valid_n;
      gap_cnt     <= gap_n;
      code_q      <= code_n;
      shift_q     <= shift_n;
      unsupported <= unsup_n;
    end
  end

  // The gap counter free-runs down to zero so a new character still honours
  // the spacing after the previous sequence's last byte.
  always_comb begin
    state_n    = state;
    sc_byte_n  = sc_byte;
    sc_valid_n = sc_valid;
    gap_n      = (gap_cnt != '0) ? gap_cnt - 1'b1 : gap_cnt;
    code_n     = code_q;
    shift_n    = shift_q;
    unsup_n    = 1'b0;
    if (state == IDLE) begin
      if (ascii_valid) begin
        if (lk[9]) begin
          code_n     = lk[7:0];
          shift_n    = lk[8];
          state_n    = lk[8] ? SH_MK : KEY_MK;
          sc_byte_n  = byte_for(state_n, lk[7:0]);
          sc_valid_n = (gap_cnt <= GW'(1));
        end else begin
          unsup_n = 1'b1;
        end
      end
    end else if (sc_valid && sc_ready) begin
      state_n = step(state, shift_q);
      gap_n   = GW'(GAP_CYCLES);
      if (state_n == IDLE) begin
        sc_valid_n = 1'b0;
      end else begin
        sc_byte_n  = byte_for(state_n, code_q);
        sc_valid_n = (GAP_CYCLES == 0);
      end
    end else if (!sc_valid && gap_cnt <= GW'(1)) begin
      sc_valid_n = 1'b1;
    end
  end

  assign ascii_ready = (state == IDLE);
  assign busy        = (state != IDLE);

endmodule

// File: tb/tb_ascii_to_scancode.sv
// Directed bench for ascii_to_scancode: one instance with GAP_CYCLES=0 and one with GAP_CYCLES=4.
module tb_ascii_to_scancode;

  typedef struct {
    logic [7:0]  c;
    bit          g0;
    int          n;
    logic [47:0] b;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [7:0] ascii = 8'h00;
  logic av0 = 1'b0, av4 = 1'b0;
  logic sc_ready = 1'b1;
  logic sel = 1'b0;
  logic rdy0, rdy4, v0, v4, busy0, busy4, un0, un4;
  logic [7:0] b0, b4;
  logic rdy_m, v_m, busy_m, un_m;
  logic [7:0] byte_m;
`ifdef CAPS_AWARE_EN
  logic caps_lock = 1'b0;
`endif

  int checks = 0;
  int errors = 0;
  vec_t vecs[17];

  always #5 clk = ~clk;

  ascii_to_scancode #(.GAP_CYCLES(0), .SHIFT_CODE(8'h12)) u_gap0 (
    .clk(clk), .rst_n(rst_n), .ascii(ascii), .ascii_valid(av0), .ascii_ready(rdy0),
    .sc_byte(b0), .sc_valid(v0), .sc_ready(sc_ready), .busy(busy0), .unsupported(un0)
`ifdef CAPS_AWARE_EN
    , .caps_lock(caps_lock)
`endif
  );

  ascii_to_scancode #(.GAP_CYCLES(4), .SHIFT_CODE(8'h12)) u_gap4 (
    .clk(clk), .rst_n(rst_n), .ascii(ascii), .ascii_valid(av4), .ascii_ready(rdy4),
    .sc_byte(b4), .sc_valid(v4), .sc_ready(sc_ready), .busy(busy4), .unsupported(un4)
`ifdef CAPS_AWARE_EN
    , .caps_lock(caps_lock)
`endif
  );

  assign rdy_m  = sel ? rdy0  : rdy4;
  assign v_m    = sel ? v0    : v4;
  assign busy_m = sel ? busy0 : busy4;
  assign un_m   = sel ? un0   : un4;
  assign byte_m = sel ? b0    : b4;

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  // Returns at the negedge following the accepting clock edge.
  task automatic accept(input logic [7:0] c, input bit g0);
    int k;
    sel = g0;
    k = 0;
    while (!rdy_m && k < 100) begin
      @(negedge clk);
      k++;
    end
    chk("accept_ready", int'(rdy_m), 1);
    ascii = c;
    if (g0) av0 = 1'b1; else av4 = 1'b1;
    @(negedge clk);
    av0 = 1'b0;
    av4 = 1'b0;
  endtask

  task automatic collect(input string name, input bit g0, output int n, output logic [47:0] got);
    int  low, busy_bad, exp_gap;
    bit  last, done;
    n = 0; got = '0; low = 0; busy_bad = 0; last = 1'b0; done = 1'b0;
    exp_gap = g0 ? 0 : 4;
    for (int cyc = 0; cyc < 400 && !done; cyc++) begin
      if (rdy_m && n > 0) begin
        done = 1'b1;
      end else begin
        if (!busy_m) busy_bad++;
        if (v_m && sc_ready) begin
          if (n > 0) chk({name, "_gap"}, low, exp_gap);
          if (n < 6) got[47-8*n -: 8] = byte_m;
          n++;
          low = 0;
          last = 1'b1;
        end else begin
          if (!v_m) low++;
          last = 1'b0;
        end
        @(negedge clk);
      end
    end
    chk({name, "_done"}, int'(done), 1);
    chk({name, "_ready_after_last"}, int'(last), 1);
    chk({name, "_busy"}, busy_bad, 0);
  endtask

  task automatic run_vec(input vec_t v, input string name);
    int          n;
    logic [47:0] got;
    int          seen;
    idle(8);
    accept(v.c, v.g0);
    if (v.n == 0) begin
      chk({name, "_unsup_pulse"}, int'(un_m), 1);
      chk({name, "_unsup_ready"}, int'(rdy_m), 1);
      seen = 0;
      @(negedge clk);
      chk({name, "_unsup_len"}, int'(un_m), 0);
      for (int i = 0; i < 10; i++) begin
        if (v_m || !rdy_m) seen++;
        @(negedge clk);
      end
      chk({name, "_unsup_quiet"}, seen, 0);
    end else begin
      chk({name, "_latency"}, int'(v_m), 1);
      collect(name, v.g0, n, got);
      chk({name, "_count"}, n, v.n);
      for (int i = 0; i < v.n; i++)
        chk($sformatf("%s_b%0d", name, i), int'(got[47-8*i -: 8]), int'(v.b[47-8*i -: 8]));
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int          n, bad, seen;
    logic [47:0] got;

    vecs[0]  = '{8'h61, 1'b1, 3, 48'h1CF01C_000000};
    vecs[1]  = '{8'h5D, 1'b1, 3, 48'h5BF05B_000000};
    vecs[2]  = '{8'h40, 1'b1, 6, 48'h121EF01EF012};
    vecs[3]  = '{8'h41, 1'b0, 6, 48'h121CF01CF012};
    vecs[4]  = '{8'h7F, 1'b0, 0, 48'h0};
    vecs[5]  = '{8'h7A, 1'b0, 3, 48'h1AF01A_000000};
    vecs[6]  = '{8'h30, 1'b0, 3, 48'h45F045_000000};
    vecs[7]  = '{8'h39, 1'b0, 3, 48'h46F046_000000};
    vecs[8]  = '{8'h29, 1'b0, 6, 48'h1245F045F012};
    vecs[9]  = '{8'h20, 1'b0, 3, 48'h29F029_000000};
    vecs[10] = '{8'h0D, 1'b0, 3, 48'h5AF05A_000000};
    vecs[11] = '{8'h7E, 1'b0, 6, 48'h120EF00EF012};
    vecs[12] = '{8'h5C, 1'b0, 3, 48'h5DF05D_000000};
    vecs[13] = '{8'h09, 1'b0, 3, 48'h0DF00D_000000};
    vecs[14] = '{8'h00, 1'b0, 0, 48'h0};
    vecs[15] = '{8'h5A, 1'b0, 6, 48'h121AF01AF012};
    vecs[16] = '{8'h08, 1'b1, 3, 48'h66F066_000000};

    rst_n = 1'b0;
    idle(3);
    chk("rst_ready", int'(rdy4), 1);
    chk("rst_valid", int'(v4), 0);
    chk("rst_busy", int'(busy4), 0);
    chk("rst_unsup", int'(un4), 0);
    chk("rst_byte", int'(b4), 0);
    chk("rst_valid_g0", int'(v0), 0);
    rst_n = 1'b1;
    idle(2);

    for (int i = 0; i < 17; i++) run_vec(vecs[i], $sformatf("v%0d", i));

    // Stall on the first byte of '?'
    idle(8);
    sc_ready = 1'b0;
    accept(8'h3F, 1'b0);
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      if (!v4 || b4 != 8'h12) bad++;
      @(negedge clk);
    end
    chk("stall_hold", bad, 0);
    sc_ready = 1'b1;
    collect("stall", 1'b0, n, got);
    chk("stall_count", n, 6);
    chk("stall_bytes", int'(got[47:16]), int'(32'h124AF04A));
    chk("stall_tail", int'(got[15:0]), int'(16'hF012));

    // Reset after the make of 'b'
    idle(8);
    accept(8'h62, 1'b0);
    chk("rstmid_make", int'(b4), 8'h32);
    @(negedge clk);
    chk("rstmid_busy_before", int'(busy4), 1);
    rst_n = 1'b0;
    #1;
    chk("rstmid_valid", int'(v4), 0);
    chk("rstmid_busy", int'(busy4), 0);
    chk("rstmid_byte", int'(b4), 0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      if (v4 || !rdy4) seen++;
      @(negedge clk);
    end
    chk("rstmid_no_break", seen, 0);
    run_vec('{8'h63, 1'b0, 3, 48'h21F021_000000}, "after_rst");

`ifdef CAPS_AWARE_EN
    caps_lock = 1'b1;
    run_vec('{8'h61, 1'b0, 6, 48'h121CF01CF012}, "caps_a");
    run_vec('{8'h41, 1'b0, 3, 48'h1CF01C_000000}, "caps_A");
    run_vec('{8'h31, 1'b0, 3, 48'h16F016_000000}, "caps_1");
    caps_lock = 1'b0;
`endif

    idle(4);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
